set_job_dispatcher: RTL

//  Upstream sequencer for the SET point-counting engine. Queues set queries from a host
//  (central, radius, mode, tag) and launches them one at a time into SET with a one-cycle
//  en pulse. It holds SET inputs stable while SET runs, captures candidate on SET's valid,
//  and returns tagged results through a ready/valid result queue.

---
 rtl/set_job_dispatcher.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/set_job_dispatcher.sv
// Job queue + launcher + result queue in front of the SET point-counting engine.
// Optional watchdog in WAIT is enabled by defining SET_DISP_TIMEOUT_EN.
module set_job_dispatcher #(
  parameter int unsigned JQ_DEPTH = 4,
  parameter int unsigned RQ_DEPTH = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TO_CYC   = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [23:0]       job_central,
  input  logic [11:0]       job_radius,
  input  logic [1:0]        job_mode,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_candidate,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err,
  output logic              set_en,
  output logic [23:0]       set_central,
  output logic [11:0]       set_radius,
  output logic [1:0]        set_mode,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [7:0]        set_candidate,
  output logic [2:0]        jobs_pending
);

  localparam int unsigned JQ_AW  = $clog2(JQ_DEPTH);
  localparam int unsigned RQ_AW  = $clog2(RQ_DEPTH);
  localparam int unsigned CENT_W = 24;
  localparam int unsigned RAD_W  = 12;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CAND_W = 8;
  localparam int unsigned JOB_W  = CENT_W + RAD_W + MODE_W + TAG_W;
  localparam int unsigned RES_W  = CAND_W + TAG_W;
  localparam int unsigned PEND_W = JQ_AW + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic jq_push, jq_pop;
  logic rq_push, rq_pop;

  // SET busy is informational only; sequencing relies on valid.
  logic unused_busy;
  assign unused_busy = set_busy;

  // ---------------------------------------------------------------- job queue
  logic [JOB_W-1:0] jq_mem [JQ_DEPTH];
  logic [JQ_AW-1:0] jq_wr_ptr, jq_rd_ptr;
  logic [JQ_AW:0]   jq_count;
  logic [JOB_W-1:0] jq_head;

  assign job_ready = (jq_count != (JQ_AW+1)'(JQ_DEPTH));
  assign jq_push   = job_valid & job_ready;
  assign jq_head   = jq_mem[jq_rd_ptr];

  always_ff @(posedge clk) begin
    if (jq_push) jq_mem[jq_wr_ptr] <= {job_central, job_radius, job_mode, job_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jq_wr_ptr <= '0;
      jq_rd_ptr <= '0;
      jq_count  <= '0;
    end else begin
      if (jq_push) jq_wr_ptr <= jq_wr_ptr + JQ_AW'(1);
      if (jq_pop)  jq_rd_ptr <= jq_rd_ptr + JQ_AW'(1);
      case ({jq_push, jq_pop})
        2'b10:   jq_count <= jq_count + (JQ_AW+1)'(1);
        2'b01:   jq_count <= jq_count - (JQ_AW+1)'(1);
        default: jq_count <= jq_count;
      endcase
    end
  end

  // ------------------------------------------------------------- result queue
  logic [RES_W-1:0] rq_mem [RQ_DEPTH];
  logic [RQ_AW-1:0] rq_wr_ptr, rq_rd_ptr;
  logic [RQ_AW:0]   rq_count;
  logic [RES_W-1:0] rq_head;
  logic [RES_W-1:0] rq_wdata;
  logic [TAG_W-1:0] cur_tag;

  assign res_valid = (rq_count != '0);
  assign rq_pop    = res_valid & res_ready;
  assign rq_head   = rq_mem[rq_rd_ptr];

  // Head fields are masked when empty so stale storage never shows after reset.
  assign res_candidate = res_valid ? rq_head[RES_W-1 -: CAND_W] : '0;
  assign res_tag       = res_valid ? rq_head[TAG_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wr_ptr] <= rq_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_wr_ptr <= '0;
      rq_rd_ptr <= '0;
      rq_count  <= '0;
    end else begin
      if (rq_push) rq_wr_ptr <= rq_wr_ptr + RQ_AW'(1);
      if (rq_pop)  rq_rd_ptr <= rq_rd_ptr + RQ_AW'(1);
      case ({rq_push, rq_pop})
        2'b10:   rq_count <= rq_count + (RQ_AW+1)'(1);
        2'b01:   rq_count <= rq_count - (RQ_AW+1)'(1);
        default: rq_count <= rq_count;
      endcase
    end
  end

  // ------------------------------------------------------------------ watchdog
`ifdef SET_DISP_TIMEOUT_EN
  localparam int unsigned TO_W = 11;

  logic [TO_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            rq_push_err;
  logic            rq_err [RQ_DEPTH];

  assign wd_expire = (wd_cnt == TO_W'(TO_CYC - 1));

  // Zeroed during LAUNCH so the first WAIT cycle sees count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) rq_err[rq_wr_ptr] <= rq_push_err;
  end

  assign res_err  = res_valid ? rq_err[rq_rd_ptr] : 1'b0;
  assign rq_wdata = rq_push_err ? {CAND_W'(0), cur_tag} : {set_candidate, cur_tag};
`else
  assign res_err  = 1'b0;
  assign rq_wdata = {set_candidate, cur_tag};
`endif

  // ----------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    jq_pop    = 1'b0;
    rq_push   = 1'b0;
`ifdef SET_DISP_TIMEOUT_EN
    rq_push_err = 1'b0;
`endif
    case (state)
      // Launch only when a result slot is free; that slot is implicitly reserved.
      S_IDLE: begin
        if ((jq_count != '0) && (rq_count != (RQ_AW+1)'(RQ_DEPTH))) begin
          jq_pop    = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (set_valid) begin
          rq_push   = 1'b1;
          state_nxt = S_GAP;
        end
`ifdef SET_DISP_TIMEOUT_EN
        else if (wd_expire) begin
          rq_push     = 1'b1;
          rq_push_err = 1'b1;
          state_nxt   = S_GAP;
        end
`endif
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- SET hold regs and en
  always_ff @(posedge clk) begin
    if (rst) begin
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      cur_tag     <= '0;
      set_en      <= 1'b0;
    end else begin
      set_en <= jq_pop;
      if (jq_pop) {set_central, set_radius, set_mode, cur_tag} <= jq_head;
    end
  end

  // ------------------------------------------------------------- occupancy
  logic [PEND_W-1:0] pend_sum;

  assign pend_sum     = PEND_W'(jq_count) + PEND_W'(state != S_IDLE);
  assign jobs_pending = (pend_sum > PEND_W'(7)) ? 3'd7 : 3'(pend_sum);

endmodule
